// File: rtl/serdes_pkg.sv
// Shared defaults and width helpers for the SERDES link buffer.
package serdes_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Bit counter only has to hold 0..n-1, so $clog2(n) bits suffice (n >= 2).
  function automatic int bit_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serdes_link_buffer_if.sv
// Client/serializer-facing signal bundle of the link buffer.
interface serdes_link_buffer_if
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  tx_ready_i;
  logic                  fifo_full_o;
  logic                  fifo_empty_o;
  logic                  serial_in_i;
  logic                  enable_i;
  logic                  start_i;
  logic [DATA_WIDTH-1:0] parallel_out_o;
  logic                  valid_out_o;

  modport slave (
    input  wr_data_i, wr_valid_i, tx_ready_i, serial_in_i, enable_i, start_i,
    output wr_ready_o, rd_data_o, rd_valid_o, fifo_full_o, fifo_empty_o,
           parallel_out_o, valid_out_o
  );

  modport master (
    output wr_data_i, wr_valid_i, tx_ready_i, serial_in_i, enable_i, start_i,
    input  wr_ready_o, rd_data_o, rd_valid_o, fifo_full_o, fifo_empty_o,
           parallel_out_o, valid_out_o
  );
endinterface

// File: rtl/sync_fifo_ff.sv
// Flop-based synchronous FIFO, first-word fall-through, registered flags.
module sync_fifo_ff
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_req,
  input  logic                  pop_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  push, pop;

  assign push    = push_req & ~full;
  assign pop     = pop_req & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Power-of-two depth: pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/serdes_link_buffer.sv
// Link endpoint: TX FIFO released one word per serializer-ready rise,
// RX deserializer rebuilding LSB-first framed words.
module serdes_link_buffer
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  serdes_link_buffer_if.slave  bus
);
  localparam int BCW = bit_cnt_w(DATA_WIDTH);

  logic full, empty;
  logic tx_ready_q, armed, rise, pop_pulse;

  sync_fifo_ff #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push_req (bus.wr_valid_i),
    .pop_req  (pop_pulse),
    .wr_data  (bus.wr_data_i),
    .rd_data  (bus.rd_data_o),
    .full     (full),
    .empty    (empty)
  );

  assign bus.wr_ready_o   = ~full;
  assign bus.rd_valid_o   = ~empty;
  assign bus.fifo_full_o  = full;
  assign bus.fifo_empty_o = empty;

  // A rise seen while empty stays armed until data shows up or ready drops.
  assign rise      = bus.tx_ready_i & ~tx_ready_q;
  assign pop_pulse = (rise | armed) & bus.tx_ready_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_ready_q <= 1'b0;
      armed      <= 1'b0;
    end else begin
      tx_ready_q <= bus.tx_ready_i;
      armed      <= bus.tx_ready_i & ~pop_pulse & (rise | armed);
    end
  end

  // Deserializer: bit 0 lands with start, the final bit goes straight into
  // parallel_out so shreg only needs the lower DATA_WIDTH-1 bits.
  logic [DATA_WIDTH-2:0] shreg;
  logic [BCW-1:0]        bit_cnt;
  logic                  frame_act;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg              <= '0;
      bit_cnt            <= '0;
      frame_act          <= 1'b0;
      bus.parallel_out_o <= '0;
      bus.valid_out_o    <= 1'b0;
    end else begin
      bus.valid_out_o <= 1'b0;
      if (bus.enable_i) begin
        if (bus.start_i) begin
          shreg     <= '0;
          shreg[0]  <= bus.serial_in_i;
          bit_cnt   <= BCW'(1);
          frame_act <= 1'b1;
        end else if (frame_act) begin
          if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
            bus.parallel_out_o <= {bus.serial_in_i, shreg};
            bus.valid_out_o    <= 1'b1;
            bit_cnt            <= '0;
            frame_act          <= 1'b0;
          end else begin
            shreg[bit_cnt] <= bus.serial_in_i;
            bit_cnt        <= bit_cnt + BCW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_serdes_link_buffer.sv
// Directed bench for serdes_link_buffer with a queue-based reference model.
module tb_serdes_link_buffer;
  import serdes_pkg::*;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serdes_link_buffer_if #(.DATA_WIDTH(W)) bus ();

  serdes_link_buffer #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, one pop per high period of ready,
  // deserializer as a bit accumulator.
  logic [W-1:0] mq[$];
  logic [W-1:0] pop_log[$];
  bit           served;
  int           rx_n;
  bit           rx_act;
  logic [W-1:0] rx_bits;
  logic [W-1:0] exp_par;
  bit           exp_vld;
  bit           m_pop, m_push;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      served  = 1'b0;
      rx_n    = 0;
      rx_act  = 1'b0;
      rx_bits = '0;
      exp_par = '0;
      exp_vld = 1'b0;
    end else begin
      m_pop  = bus.tx_ready_i && !served && (mq.size() != 0);
      m_push = bus.wr_valid_i && (mq.size() != D);
      if (!bus.tx_ready_i) served = 1'b0;
      else if (m_pop)      served = 1'b1;
      if (m_pop)  pop_log.push_back(mq.pop_front());
      if (m_push) mq.push_back(bus.wr_data_i);
      exp_vld = 1'b0;
      if (bus.enable_i) begin
        if (bus.start_i) begin
          rx_bits = W'(bus.serial_in_i);
          rx_n    = 1;
          rx_act  = 1'b1;
        end else if (rx_act) begin
          rx_bits[rx_n] = bus.serial_in_i;
          rx_n++;
          if (rx_n == W) begin
            exp_par = rx_bits;
            exp_vld = 1'b1;
            rx_act  = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("wr_ready", bus.wr_ready_o,   mq.size() != D);
    check("full",     bus.fifo_full_o,  mq.size() == D);
    check("empty",    bus.fifo_empty_o, mq.size() == 0);
    check("rd_valid", bus.rd_valid_o,   mq.size() != 0);
    if (mq.size() != 0) check("rd_data", bus.rd_data_o, mq[0]);
    check("parallel_out", bus.parallel_out_o, exp_par);
    check("valid_out",    bus.valid_out_o,    exp_vld);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_bit(input logic b, input logic st);
    bus.serial_in_i = b;
    bus.enable_i    = 1'b1;
    bus.start_i     = st;
    step(1);
    bus.enable_i    = 1'b0;
    bus.start_i     = 1'b0;
  endtask

  logic [7:0] v;
  logic [7:0] pushes [5];

  initial begin
    bus.wr_data_i   = '0;
    bus.wr_valid_i  = 1'b0;
    bus.tx_ready_i  = 1'b0;
    bus.serial_in_i = 1'b0;
    bus.enable_i    = 1'b0;
    bus.start_i     = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_empty", bus.fifo_empty_o, 1);
    check("rst_full",  bus.fifo_full_o,  0);
    check("rst_par",   bus.parallel_out_o, 0);
    check("rst_vld",   bus.valid_out_o,  0);

    // Fill to full; fifth word must be dropped.
    pushes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = pushes[i];
      step(1);
    end
    bus.wr_valid_i = 1'b0;
    check("fill_full",     bus.fifo_full_o, 1);
    check("fill_wr_ready", bus.wr_ready_o,  0);
    check("fill_head",     bus.rd_data_o,   8'hA1);

    // Level high for 5 cycles: one pop only.
    bus.tx_ready_i = 1'b1;
    step(5);
    bus.tx_ready_i = 1'b0;
    step(1);
    check("hold_pops", pop_log.size(), 1);
    check("hold_head", bus.rd_data_o, 8'hB2);

    for (int i = 0; i < 3; i++) begin
      bus.tx_ready_i = 1'b1;
      step(1);
      bus.tx_ready_i = 1'b0;
      step(1);
    end
    check("toggle_pops", pop_log.size(), 4);
    check("order0", pop_log[0], 8'hA1);
    check("order1", pop_log[1], 8'hB2);
    check("order2", pop_log[2], 8'hC3);
    check("order3", pop_log[3], 8'hD4);
    check("drained_empty", bus.fifo_empty_o, 1);

    // Ready rises while empty; the pop is deferred to the first non-empty cycle.
    bus.tx_ready_i = 1'b1;
    step(2);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 8'h5A;
    step(1);
    bus.wr_valid_i = 1'b0;
    check("defer_head",  bus.rd_data_o,    8'h5A);
    check("defer_nempty", bus.fifo_empty_o, 0);
    step(1);
    check("defer_empty", bus.fifo_empty_o, 1);
    check("defer_popped", pop_log[pop_log.size()-1], 8'h5A);
    bus.tx_ready_i = 1'b0;
    step(1);

    // Simultaneous push and pop at count 2.
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 8'h11;
    step(1);
    bus.wr_data_i  = 8'h22;
    step(1);
    bus.wr_data_i  = 8'h33;
    bus.tx_ready_i = 1'b1;
    step(1);
    bus.wr_valid_i = 1'b0;
    check("simul_head", bus.rd_data_o, 8'h22);
    check("simul_size", mq.size(), 2);
    bus.tx_ready_i = 1'b0;
    step(1);

    // Nine push+pop rounds walk both pointers around several times.
    for (int i = 0; i < 9; i++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 8'h60 + 8'(i);
      bus.tx_ready_i = 1'b1;
      step(1);
      bus.wr_valid_i = 1'b0;
      bus.tx_ready_i = 1'b0;
      step(1);
    end
    check("wrap_head", bus.rd_data_o, 8'h67);
    for (int i = 0; i < 2; i++) begin
      bus.tx_ready_i = 1'b1;
      step(1);
      bus.tx_ready_i = 1'b0;
      step(1);
    end
    check("wrap_empty", bus.fifo_empty_o, 1);

    // 0xA5 LSB-first with gaps between enabled bits.
    v = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      rx_bit(v[i], i == 0);
      if (i == 7) begin
        check("a5_vld",  bus.valid_out_o,    1);
        check("a5_data", bus.parallel_out_o, 8'hA5);
      end else check("a5_novld", bus.valid_out_o, 0);
      step(1);
    end
    check("a5_pulse_end", bus.valid_out_o, 0);

    // Partial frame of three bits aborted by a new start carrying 0x3C.
    v = 8'hFF;
    for (int i = 0; i < 3; i++) rx_bit(v[i], i == 0);
    v = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      rx_bit(v[i], i == 0);
      if (i < 7) check("3c_novld", bus.valid_out_o, 0);
    end
    check("3c_vld",  bus.valid_out_o,    1);
    check("3c_data", bus.parallel_out_o, 8'h3C);

    // Start without enable, and enabled bits outside a frame, are ignored.
    bus.start_i = 1'b1;
    step(1);
    bus.start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_bit(1'b1, 1'b0);
      check("idle_novld", bus.valid_out_o, 0);
    end
    check("idle_hold", bus.parallel_out_o, 8'h3C);

    // Reset in the middle of a frame.
    v = 8'h0F;
    for (int i = 0; i < 4; i++) rx_bit(v[i], i == 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rstmid_par", bus.parallel_out_o, 0);
    check("rstmid_vld", bus.valid_out_o,    0);
    for (int i = 4; i < 8; i++) begin
      rx_bit(v[i], 1'b0);
      check("rstmid_novld", bus.valid_out_o, 0);
    end
    step(2);
    check("rstmid_par_end", bus.parallel_out_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
